// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared register-file constants for the MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [31:0] SP_INIT = 32'h0000_3FFC;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational read port with write bypass and $0 forcing.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] index,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] dest,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] arrayWord,
  input  logic              reset,
  output logic [DATA_W-1:0] readData
);

  logic w_bypassHit;

  // A reset cycle shows the array, never the write that reset is about to drop.
  assign w_bypassHit = !reset && writeEn && (dest != '0) && (dest == index);

  always_comb begin
    readData = arrayWord;
    if (w_bypassHit) begin
      readData = writeData;
    end else if (index == '0) begin
      readData = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : register_file_wb
// Description : 32x32 MIPS register file fed by writeback; two decode read
//               ports plus a debug port, all with same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_wb #(
  parameter int                DATA_W  = mips_pkg::DATA_W,
  parameter int                ADDR_W  = mips_pkg::ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(mips_pkg::SP_INIT)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWriteW,
  input  logic              jalW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] WriteDataW,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData
);

  import mips_pkg::*;

  localparam int                NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_regZero = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] c_regRa   = ADDR_W'(REG_RA);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_writeEn;
  logic [ADDR_W-1:0] w_dest;

  // JAL always links into $ra regardless of the decoded destination field.
  assign w_writeEn = RegWriteW | jalW;
  assign w_dest    = jalW ? c_regRa : WriteRegW;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (w_writeEn && (w_dest != c_regZero)) begin
      r_regs[w_dest] <= WriteDataW;
    end
  end

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_portRs (
    .index    (ReadReg1),
    .writeEn  (w_writeEn),
    .dest     (w_dest),
    .writeData(WriteDataW),
    .arrayWord(r_regs[ReadReg1]),
    .reset    (Reset),
    .readData (ReadData1)
  );

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_portRt (
    .index    (ReadReg2),
    .writeEn  (w_writeEn),
    .dest     (w_dest),
    .writeData(WriteDataW),
    .arrayWord(r_regs[ReadReg2]),
    .reset    (Reset),
    .readData (ReadData2)
  );

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_portDbg (
    .index    (DbgReg),
    .writeEn  (w_writeEn),
    .dest     (w_dest),
    .writeData(WriteDataW),
    .arrayWord(r_regs[DbgReg]),
    .reset    (Reset),
    .readData (DbgData)
  );

endmodule
`default_nettype wire

// File: tb/tb_register_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_wb
// Description : Directed self-checking bench for register_file_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_wb;

  localparam logic [31:0] c_spInit = 32'h0000_3FFC;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWriteW;
  logic        jalW;
  logic [4:0]  WriteRegW;
  logic [31:0] WriteDataW;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DbgReg;
  logic [31:0] DbgData;

  int tests  = 0;
  int failed = 0;

  always #5 Clk = ~Clk;

  register_file_wb dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .RegWriteW (RegWriteW),
    .jalW      (jalW),
    .WriteRegW (WriteRegW),
    .WriteDataW(WriteDataW),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .DbgReg    (DbgReg),
    .DbgData   (DbgData)
  );

  // Advance past a rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWriteW  = 1'b0;
    jalW       = 1'b0;
    WriteRegW  = 5'd0;
    WriteDataW = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(i);
      DbgReg   = 5'(i);
      #1;
      exp = (i == 29) ? c_spInit : 32'h0;
      tests++;
      if (ReadData1 !== exp) begin
        failed++;
        $display("FAIL reset_rd1[%0d] got %h want %h", i, ReadData1, exp);
      end
      tests++;
      if (ReadData2 !== exp) begin
        failed++;
        $display("FAIL reset_rd2[%0d] got %h want %h", i, ReadData2, exp);
      end
      tests++;
      if (DbgData !== exp) begin
        failed++;
        $display("FAIL reset_dbg[%0d] got %h want %h", i, DbgData, exp);
      end
    end
  endtask

  task automatic test_bypass();
    RegWriteW  = 1'b1;
    WriteRegW  = 5'd8;
    WriteDataW = 32'hDEAD_BEEF;
    ReadReg1   = 5'd8;
    #1;
    tests++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      failed++;
      $display("FAIL bypass_same_cycle got %h want %h", ReadData1, 32'hDEAD_BEEF);
    end
    tick();
    idle();
    #1;
    tests++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      failed++;
      $display("FAIL bypass_stored got %h want %h", ReadData1, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_zero();
    RegWriteW  = 1'b1;
    WriteRegW  = 5'd0;
    WriteDataW = 32'h1234_5678;
    ReadReg2   = 5'd0;
    DbgReg     = 5'd0;
    #1;
    tests++;
    if (ReadData2 !== 32'h0) begin
      failed++;
      $display("FAIL zero_bypass got %h want %h", ReadData2, 32'h0);
    end
    tests++;
    if (DbgData !== 32'h0) begin
      failed++;
      $display("FAIL zero_dbg_bypass got %h want %h", DbgData, 32'h0);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (ReadData2 !== 32'h0) begin
        failed++;
        $display("FAIL zero_after[%0d] got %h want %h", c, ReadData2, 32'h0);
      end
      tick();
    end
  endtask

  task automatic test_jal();
    jalW       = 1'b1;
    RegWriteW  = 1'b0;
    WriteRegW  = 5'd5;
    WriteDataW = 32'h0000_0048;
    DbgReg     = 5'd31;
    ReadReg1   = 5'd5;
    #1;
    tests++;
    if (DbgData !== 32'h48) begin
      failed++;
      $display("FAIL jal_dbg_bypass got %h want %h", DbgData, 32'h48);
    end
    tests++;
    if (ReadData1 !== 32'h0) begin
      failed++;
      $display("FAIL jal_no_bypass_r5 got %h want %h", ReadData1, 32'h0);
    end
    tick();
    idle();
    ReadReg1 = 5'd31;
    ReadReg2 = 5'd5;
    #1;
    tests++;
    if (ReadData1 !== 32'h48) begin
      failed++;
      $display("FAIL jal_ra_stored got %h want %h", ReadData1, 32'h48);
    end
    tests++;
    if (ReadData2 !== 32'h0) begin
      failed++;
      $display("FAIL jal_r5_unchanged got %h want %h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    RegWriteW  = 1'b1;
    WriteRegW  = 5'd9;
    WriteDataW = 32'hAAAA_0001;
    tick();
    Reset      = 1'b1;
    RegWriteW  = 1'b1;
    WriteRegW  = 5'd9;
    WriteDataW = 32'h0000_5555;
    ReadReg1   = 5'd9;
    #1;
    tests++;
    if (ReadData1 !== 32'hAAAA_0001) begin
      failed++;
      $display("FAIL rst_no_bypass got %h want %h", ReadData1, 32'hAAAA_0001);
    end
    tick();
    Reset = 1'b0;
    idle();
    ReadReg2 = 5'd31;
    DbgReg   = 5'd29;
    #1;
    tests++;
    if (ReadData1 !== 32'h0) begin
      failed++;
      $display("FAIL rst_r9_cleared got %h want %h", ReadData1, 32'h0);
    end
    tests++;
    if (ReadData2 !== 32'h0) begin
      failed++;
      $display("FAIL rst_ra_cleared got %h want %h", ReadData2, 32'h0);
    end
    tests++;
    if (DbgData !== c_spInit) begin
      failed++;
      $display("FAIL rst_sp_init got %h want %h", DbgData, c_spInit);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'd1;
    vals[1] = 32'd2;
    vals[2] = 32'd3;
    ReadReg1 = 5'd12;
    for (int k = 0; k < 3; k++) begin
      RegWriteW  = 1'b1;
      WriteRegW  = 5'd12;
      WriteDataW = vals[k];
      #1;
      tests++;
      if (ReadData1 !== vals[k]) begin
        failed++;
        $display("FAIL b2b_bypass[%0d] got %h want %h", k, ReadData1, vals[k]);
      end
      tick();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (ReadData1 !== 32'd3) begin
        failed++;
        $display("FAIL b2b_hold[%0d] got %h want %h", c, ReadData1, 32'd3);
      end
      tick();
    end
  endtask

  task automatic test_dual_read();
    ReadReg1   = 5'd12;
    ReadReg2   = 5'd12;
    RegWriteW  = 1'b1;
    WriteRegW  = 5'd12;
    WriteDataW = 32'hCAFE_0007;
    #1;
    tests++;
    if (ReadData1 !== 32'hCAFE_0007 || ReadData2 !== 32'hCAFE_0007) begin
      failed++;
      $display("FAIL dual_bypass got %h/%h want %h", ReadData1, ReadData2, 32'hCAFE_0007);
    end
    tick();
    idle();
    ReadReg1 = 5'd29;
    ReadReg2 = 5'd29;
    #1;
    tests++;
    if (ReadData1 !== c_spInit || ReadData2 !== c_spInit) begin
      failed++;
      $display("FAIL dual_sp got %h/%h want %h", ReadData1, ReadData2, c_spInit);
    end
  endtask

  initial begin
    Reset    = 1'b1;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    DbgReg   = 5'd0;
    idle();
    #1;
    test_reset();
    test_bypass();
    test_zero();
    test_jal();
    test_reset_priority();
    test_back_to_back();
    test_dual_read();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- 32x32 MIPS general-purpose register file, directly downstream of the writeback stage; consumes its final write-data word.
- Provides two combinational read ports for the decode stage and one debug read port.
- Writes occur at the clock edge.
- Includes an internal write-to-read bypass, so decode sees a same-cycle writeback value without a separate forwarding path.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width
- SP_INIT, 32'h0000_3FFC, value loaded into $29 ($sp) on reset

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- RegWriteW  input  1  write enable from writeback stage
- jalW  input  1  jump-and-link in writeback; forces destination to $31 and forces a write
- WriteRegW  input  ADDR_W  destination register index from writeback
- WriteDataW  input  DATA_W  final write data (MemtoReg/JAL mux output)
- ReadReg1  input  ADDR_W  rs index from decode
- ReadReg2  input  ADDR_W  rt index from decode
- ReadData1  output  DATA_W  rs value
- ReadData2  output  DATA_W  rt value
- DbgReg  input  ADDR_W  debug/display register index
- DbgData  output  DATA_W  debug register value, bypass applied

Behaviour:
- Storage: 32 entries x DATA_W.
- Effective write enable: WE = RegWriteW | jalW.
- Effective destination: DEST = jalW ? 31 : WriteRegW.
- Write: on rising Clk with Reset=0 and WE=1 and DEST!=0, reg[DEST] <= WriteDataW. Visible in the array from the next cycle.
- $0: never written. A write attempt to index 0 is silently dropped. Reads of index 0 always return 0, including via bypass.
- Reset: on rising Clk with Reset=1, every entry is cleared to 0 except $29, which loads SP_INIT.
  - Reset has priority over a simultaneous write; the write is lost.
  - Reset mid-program discards all architectural state.
- Read ports (x3) are purely combinational, 0-cycle latency.
  - If Reset=0, WE=1, DEST!=0 and DEST==read index: output WriteDataW (bypass).
  - Else if read index==0: output 0.
  - Else: output reg[index].
- Bypass is suppressed while Reset=1; outputs show array contents.
- Output reset values: after the reset edge, all read outputs are 0 except any port addressing 29, which reads SP_INIT.
- jalW with RegWriteW=0 still writes PC+4, i.e. whatever WriteDataW carries, to $31.
- jalW with WriteRegW!=31: WriteRegW is ignored.
- ReadReg1==ReadReg2: both ports return identical values, bypass included.
- Same-index write on consecutive cycles: the last write wins; the bypass always reflects the current-cycle WriteDataW.
- No X propagation: the array is fully defined after the first reset. Reads before the first reset are undefined and must not be checked.

Decomposition:
- Shared package (mips_pkg): constants REG_ZERO=0, REG_SP=29, REG_RA=31, DATA_W, ADDR_W, SP_INIT default.
- Sub-module regfile_read_port: inputs index, write-enable, destination, write data, array word and reset; output read value. Implements the bypass/zero logic and is instantiated three times (rs, rt, debug).
- Top module holds the array, write/reset sequencing and DEST/WE derivation.

Test Plan:
- Reset, then read all 32 indices -> all 0 except index 29 = 32'h0000_3FFC.
- RegWriteW=1, WriteRegW=8, WriteDataW=32'hDEAD_BEEF, ReadReg1=8 in the same cycle -> ReadData1=32'hDEAD_BEEF that cycle (bypass), and still DEAD_BEEF next cycle with RegWriteW=0.
- RegWriteW=1, WriteRegW=0, WriteDataW=32'h1234_5678, ReadReg2=0 -> ReadData2=0 that cycle and every cycle after.
- jalW=1, RegWriteW=0, WriteRegW=5, WriteDataW=32'h0000_0048 -> $31 = 32'h48 next cycle, $5 unchanged. DbgReg=31 shows 32'h48 during the write cycle.
- Write $9=32'hAAAA_0001, then next cycle Reset=1 together with RegWriteW=1, WriteRegW=9, WriteDataW=32'h5555 -> $9=0 after the edge and ReadData1 (ReadReg1=9) shows no bypass during the Reset cycle.
- Back-to-back writes to $12 of 1, 2, 3 on consecutive cycles, with ReadReg1=12 held -> ReadData1 sequence 1, 2, 3 (bypass), then 3 once writes stop.
